// File: rtl/risc_hazard_unit_if.sv
// Handshake bundle between the Datapath_Unit (master) and the pipeline hazard controller (slave).
interface risc_hazard_unit_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic [REG_AW-1:0] id_rd;
  logic              id_rf_write;
  logic              id_is_load;
  logic              ex_redirect;
  logic              dmem_busy;

  logic              pc_en;
  logic              ifid_en;
  logic              ifid_flush;
  logic              idex_bubble;
  logic              pipe_en;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_rf_write, id_is_load, ex_redirect, dmem_busy,
    input  pc_en, ifid_en, ifid_flush, idex_bubble, pipe_en,
           fwd_a, fwd_b, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_rf_write, id_is_load, ex_redirect, dmem_busy,
    output pc_en, ifid_en, ifid_flush, idex_bubble, pipe_en,
           fwd_a, fwd_b, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/risc_hazard_unit.sv
// Hazard, stall and forwarding controller for the 5-stage IF/ID/EX/MEM/WB pipeline.
// Define RISC_HAZARD_FWD_EN for operand forwarding; without it RAW hazards stall until WB.
module risc_hazard_unit #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input logic               clk,
  input logic               rst,
  risc_hazard_unit_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_RUN,
    MODE_LOADUSE,
    MODE_REDIRECT,
    MODE_FREEZE
  } mode_e;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              rf_write;
    logic              is_load;
  } stage_t;

  typedef struct packed {
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              use1;
    logic              use2;
  } ex_src_t;

  stage_t           r_ex;
  stage_t           r_mem;
  stage_t           r_wb;
  ex_src_t          r_ex_src;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  mode_e w_mode;
  logic  w_hazard;

  // Register 0 is hard-wired zero, so it never produces a hazard or a forward.
  function automatic logic stage_writes(input logic              valid,
                                        input logic              rf_write,
                                        input logic [REG_AW-1:0] rd,
                                        input logic [REG_AW-1:0] r);
    return valid && rf_write && (rd == r) && (r != '0);
  endfunction

`ifdef RISC_HAZARD_FWD_EN
  always_comb begin
    w_hazard = bus.id_valid && r_ex.is_load &&
      ((bus.id_use_rs1 && stage_writes(r_ex.valid, r_ex.rf_write, r_ex.rd, bus.id_rs1)) ||
       (bus.id_use_rs2 && stage_writes(r_ex.valid, r_ex.rf_write, r_ex.rd, bus.id_rs2)));
  end
`else
  // Without forwarding any producer in EX or MEM blocks a reader; WB is covered by write-before-read.
  always_comb begin
    w_hazard = bus.id_valid &&
      ((bus.id_use_rs1 && (stage_writes(r_ex.valid,  r_ex.rf_write,  r_ex.rd,  bus.id_rs1) ||
                           stage_writes(r_mem.valid, r_mem.rf_write, r_mem.rd, bus.id_rs1))) ||
       (bus.id_use_rs2 && (stage_writes(r_ex.valid,  r_ex.rf_write,  r_ex.rd,  bus.id_rs2) ||
                           stage_writes(r_mem.valid, r_mem.rf_write, r_mem.rd, bus.id_rs2))));
  end
`endif

  always_comb begin
    if (bus.dmem_busy)        w_mode = MODE_FREEZE;
    else if (bus.ex_redirect) w_mode = MODE_REDIRECT;
    else if (w_hazard)        w_mode = MODE_LOADUSE;
    else                      w_mode = MODE_RUN;
  end

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
    bus.pc_en       = 1'b1;
    bus.ifid_en     = 1'b1;
    bus.ifid_flush  = 1'b0;
    bus.idex_bubble = 1'b0;
    bus.pipe_en     = 1'b1;
    if (rst) begin
      bus.pc_en       = 1'b0;
      bus.ifid_en     = 1'b0;
      bus.ifid_flush  = 1'b1;
      bus.idex_bubble = 1'b1;
    end else begin
      unique case (w_mode)
        MODE_FREEZE: begin
          bus.pc_en   = 1'b0;
          bus.ifid_en = 1'b0;
          bus.pipe_en = 1'b0;
        end
        MODE_REDIRECT: begin
          bus.ifid_flush  = 1'b1;
          bus.idex_bubble = 1'b1;
        end
        MODE_LOADUSE: begin
          bus.pc_en       = 1'b0;
          bus.ifid_en     = 1'b0;
          bus.idex_bubble = 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef RISC_HAZARD_FWD_EN
  // A load in MEM has no result yet, so its consumer waits one cycle and takes it from MEM/WB.
  function automatic logic [1:0] fwd_sel(input stage_t            mem,
                                          input logic [REG_AW-1:0] wb_rd,
                                          input logic              wb_valid,
                                          input logic              wb_rf_write,
                                          input logic [REG_AW-1:0] rs,
                                          input logic              use_rs);
    if (use_rs && !mem.is_load && stage_writes(mem.valid, mem.rf_write, mem.rd, rs))
      return 2'b10;
    if (use_rs && stage_writes(wb_valid, wb_rf_write, wb_rd, rs))
      return 2'b01;
    return 2'b00;
  endfunction

  always_comb begin
    bus.fwd_a = 2'b00;
    bus.fwd_b = 2'b00;
    if (!rst) begin
      bus.fwd_a = fwd_sel(r_mem, r_wb.rd, r_wb.valid, r_wb.rf_write, r_ex_src.rs1, r_ex_src.use1);
      bus.fwd_b = fwd_sel(r_mem, r_wb.rd, r_wb.valid, r_wb.rf_write, r_ex_src.rs2, r_ex_src.use2);
    end
  end

  logic w_unused_fwd;
  assign w_unused_fwd = r_wb.is_load;
`else
  always_comb begin
    bus.fwd_a = 2'b00;
    bus.fwd_b = 2'b00;
  end

  logic w_unused_nofwd;
  assign w_unused_nofwd = ^{r_ex_src, r_wb, r_ex.is_load, r_mem.is_load};
`endif

  // NOTE: sequential state uses non-blocking assignments so mem <= ex and wb <= mem shift together.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: only valid bits and counters are reset; payload fields are ignored while invalid.
      r_ex.valid  <= 1'b0;
      r_mem.valid <= 1'b0;
      r_wb.valid  <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      unique case (w_mode)
        MODE_FREEZE: ;
        MODE_REDIRECT: begin
          r_ex.valid <= 1'b0;
          r_mem      <= r_ex;
          r_wb       <= r_mem;
          if (r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
        MODE_LOADUSE: begin
          r_ex.valid <= 1'b0;
          r_mem      <= r_ex;
          r_wb       <= r_mem;
          if (r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
        default: begin
          r_ex     <= '{valid: bus.id_valid, rd: bus.id_rd,
                        rf_write: bus.id_rf_write, is_load: bus.id_is_load};
          r_ex_src <= '{rs1: bus.id_rs1, rs2: bus.id_rs2,
                        use1: bus.id_use_rs1, use2: bus.id_use_rs2};
          r_mem    <= r_ex;
          r_wb     <= r_mem;
        end
      endcase
    end
  end

  assign bus.stall_cnt = r_stall_cnt;
  assign bus.flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_risc_hazard_unit.sv
// Directed bench for risc_hazard_unit; expectations follow RISC_HAZARD_FWD_EN when it is defined.
module tb_risc_hazard_unit;

  localparam logic [4:0] C_RUN    = 5'b11001;  // {pc_en, ifid_en, ifid_flush, idex_bubble, pipe_en}
  localparam logic [4:0] C_STALL  = 5'b00011;
  localparam logic [4:0] C_REDIR  = 5'b11111;
  localparam logic [4:0] C_FREEZE = 5'b00000;
  localparam logic [4:0] C_RESET  = 5'b00111;

`ifdef RISC_HAZARD_FWD_EN
  localparam int         ALU_STALL = 0;
  localparam int         LD_STALL  = 1;
  localparam logic [1:0] FW_MEM    = 2'b10;
  localparam logic [1:0] FW_WB     = 2'b01;
`else
  localparam int         ALU_STALL = 2;
  localparam int         LD_STALL  = 2;
  localparam logic [1:0] FW_MEM    = 2'b00;
  localparam logic [1:0] FW_WB     = 2'b00;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  int   exp_stall = 0;
  int   exp_flush = 0;

  risc_hazard_unit_if #(.REG_AW(5), .CNT_W(16)) bus ();
  risc_hazard_unit_if #(.REG_AW(5), .CNT_W(2))  bus_s ();

  risc_hazard_unit #(.REG_AW(5), .CNT_W(16)) dut   (.clk(clk), .rst(rst), .bus(bus));
  risc_hazard_unit #(.REG_AW(5), .CNT_W(2))  dut_s (.clk(clk), .rst(rst), .bus(bus_s));

  assign bus_s.id_valid    = bus.id_valid;
  assign bus_s.id_rs1      = bus.id_rs1;
  assign bus_s.id_rs2      = bus.id_rs2;
  assign bus_s.id_use_rs1  = bus.id_use_rs1;
  assign bus_s.id_use_rs2  = bus.id_use_rs2;
  assign bus_s.id_rd       = bus.id_rd;
  assign bus_s.id_rf_write = bus.id_rf_write;
  assign bus_s.id_is_load  = bus.id_is_load;
  assign bus_s.ex_redirect = bus.ex_redirect;
  assign bus_s.dmem_busy   = bus.dmem_busy;

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic [4:0] exp);
    chk({tag, ":ctl"}, 32'({bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_bubble, bus.pipe_en}),
        32'(exp));
  endtask

  task automatic chk_fwd(input string tag, input logic [1:0] a, input logic [1:0] b);
    chk({tag, ":fwd_a"}, 32'(bus.fwd_a), 32'(a));
    chk({tag, ":fwd_b"}, 32'(bus.fwd_b), 32'(b));
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, ":stall_cnt"}, 32'(bus.stall_cnt), 32'(exp_stall));
    chk({tag, ":flush_cnt"}, 32'(bus.flush_cnt), 32'(exp_flush));
  endtask

  task automatic set_id(input logic v, input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2, input logic wr, input logic ld);
    bus.id_valid    = v;
    bus.id_rd       = rd;
    bus.id_rs1      = rs1;
    bus.id_use_rs1  = u1;
    bus.id_rs2      = rs2;
    bus.id_use_rs2  = u2;
    bus.id_rf_write = wr;
    bus.id_is_load  = ld;
  endtask

  task automatic i_nop();
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic i_alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    set_id(1'b1, rd, rs1, 1'b1, rs2, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic i_lw(input logic [4:0] rd, input logic [4:0] rs1);
    set_id(1'b1, rd, rs1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic cycle(input string tag, input logic [4:0] exp);
    settle();
    chk_ctl(tag, exp);
    tick();
  endtask

  task automatic drain();
    i_nop();
    repeat (3) cycle("drain", C_RUN);
  endtask

  // lw r6,0(r1) followed by add r7,r6,r6, optionally frozen before the stall resolves.
  task automatic lu_pair(input string tag, input int n_freeze);
    i_lw(5'd6, 5'd1);
    cycle({tag, "-lw"}, C_RUN);
    i_alu(5'd7, 5'd6, 5'd6);
    bus.dmem_busy = 1'b1;
    for (int k = 0; k < n_freeze; k++) begin
      settle();
      chk_cnt({tag, "-freeze"});
      cycle({tag, "-freeze"}, C_FREEZE);
    end
    bus.dmem_busy = 1'b0;
    for (int k = 0; k < LD_STALL; k++) begin
      cycle({tag, "-stall"}, C_STALL);
      exp_stall++;
    end
    cycle({tag, "-go"}, C_RUN);
  endtask

  initial begin
    bus.ex_redirect = 1'b0;
    bus.dmem_busy   = 1'b0;
    i_nop();

    // Reset for 3 cycles; busy/redirect must not override the reset outputs.
    settle();
    chk_ctl("rst0", C_RESET);
    chk_fwd("rst0", 2'b00, 2'b00);
    tick();
    bus.ex_redirect = 1'b1;
    bus.dmem_busy   = 1'b1;
    cycle("rst1", C_RESET);
    bus.ex_redirect = 1'b0;
    bus.dmem_busy   = 1'b0;
    cycle("rst2", C_RESET);
    chk_cnt("rst");
    rst = 1'b0;

    // add r3,r1,r2 ; sub r4,r3,r5
    i_alu(5'd3, 5'd1, 5'd2);
    settle();
    chk_ctl("add", C_RUN);
    chk_cnt("post_rst");
    tick();
    i_alu(5'd4, 5'd3, 5'd5);
    for (int k = 0; k < ALU_STALL; k++) begin
      cycle("sub-stall", C_STALL);
      exp_stall++;
    end
    cycle("sub", C_RUN);
    i_nop();
    settle();
    chk_fwd("sub_in_ex", FW_MEM, 2'b00);
    chk_cnt("sub");
    tick();
    drain();

    // lw r6 ; add r7,r6,r6 -> consumer reads the load from MEM/WB
    lu_pair("lu", 0);
    i_nop();
    settle();
    chk_fwd("lu_in_ex", FW_WB, FW_WB);
    chk_cnt("lu");
    tick();
    drain();

    // Redirect wins over a load-use victim in ID.
    i_lw(5'd6, 5'd1);
    cycle("redir-lw", C_RUN);
    i_alu(5'd7, 5'd6, 5'd6);
    bus.ex_redirect = 1'b1;
    cycle("redir", C_REDIR);
    exp_flush++;
    bus.ex_redirect = 1'b0;
    i_nop();
    settle();
    chk_cnt("redir");
    tick();
    drain();

    // Four frozen cycles with a pending redirect, then the redirect lands.
    i_alu(5'd9, 5'd1, 5'd2);
    bus.ex_redirect = 1'b1;
    bus.dmem_busy   = 1'b1;
    repeat (4) begin
      settle();
      chk_ctl("freeze", C_FREEZE);
      chk_cnt("freeze");
      tick();
    end
    bus.dmem_busy = 1'b0;
    cycle("freeze-redir", C_REDIR);
    exp_flush++;
    bus.ex_redirect = 1'b0;
    i_nop();
    settle();
    chk_cnt("freeze-redir");
    tick();
    drain();

    // Scoreboard holds while frozen mid load-use.
    lu_pair("lu-frz", 2);
    drain();

    // r0 never stalls or forwards.
    i_alu(5'd0, 5'd1, 5'd2);
    cycle("r0-wr", C_RUN);
    i_alu(5'd10, 5'd0, 5'd0);
    cycle("r0-rd", C_RUN);
    i_nop();
    settle();
    chk_fwd("r0", 2'b00, 2'b00);
    tick();
    i_lw(5'd0, 5'd1);
    cycle("r0-lw", C_RUN);
    i_alu(5'd11, 5'd0, 5'd0);
    cycle("r0-lu", C_RUN);
    drain();

    // Back-to-back load-use pairs drive the 2-bit counters into saturation.
    for (int p = 0; p < 5; p++) lu_pair("sat", 0);
    settle();
    chk_cnt("sat16");
    chk("sat2:stall_cnt", 32'(bus_s.stall_cnt), 32'((exp_stall > 3) ? 3 : exp_stall));
    chk("sat2:flush_cnt", 32'(bus_s.flush_cnt), 32'((exp_flush > 3) ? 3 : exp_flush));
    tick();
    drain();

    // Reset in the middle of a stall aborts it.
    i_lw(5'd6, 5'd1);
    cycle("rst-lw", C_RUN);
    i_alu(5'd7, 5'd6, 5'd6);
    settle();
    chk_ctl("rst-pre", C_STALL);
    rst = 1'b1;
    settle();
    chk_ctl("rst-mid", C_RESET);
    tick();
    rst = 1'b0;
    exp_stall = 0;
    exp_flush = 0;
    settle();
    chk_ctl("rst-after", C_RUN);
    chk_cnt("rst-after");
    chk("rst-after:sat2", 32'(bus_s.stall_cnt), 32'(0));
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/risc_hazard_unit.md
Name: risc_hazard_unit

Overview:
- Parametrised hazard, stall and forwarding controller for the 5-stage pipelined successor of risc_32_bit: IF, ID, EX, MEM, WB.
- Keeps a registered scoreboard of the instructions in EX, MEM and WB.
- Generates per-stage enable, flush and bubble controls and operand-forwarding selects for the Datapath_Unit.
- Handles load-use stalls, EX-resolved branch/jump flushes and data-memory back-pressure, and keeps saturating performance counters.

Parameters:
- REG_AW, 5: register-file address width; register index 0 is hard-wired zero.
- CNT_W, 16: width of the stall and flush performance counters.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous active-high reset.
- id_valid  in  1  a valid instruction occupies ID.
- id_rs1  in  REG_AW  ID source 1 index.
- id_rs2  in  REG_AW  ID source 2 index.
- id_use_rs1  in  1  ID instruction reads rs1.
- id_use_rs2  in  1  ID instruction reads rs2.
- id_rd  in  REG_AW  ID destination index.
- id_rf_write  in  1  ID instruction writes the register file.
- id_is_load  in  1  ID instruction is a load (mem_to_reg selects memory).
- ex_redirect  in  1  branch taken or jump resolved in EX this cycle.
- dmem_busy  in  1  data memory cannot complete the MEM access this cycle.
- pc_en  out  1  PC update enable.
- ifid_en  out  1  IF/ID register enable.
- ifid_flush  out  1  IF/ID loads a NOP.
- idex_bubble  out  1  ID/EX loads a NOP.
- pipe_en  out  1  enable for ID/EX, EX/MEM and MEM/WB.
- fwd_a  out  2  EX operand A select: 00 = RF, 10 = EX/MEM result, 01 = MEM/WB result.
- fwd_b  out  2  EX operand B select, same encoding as fwd_a.
- stall_cnt  out  CNT_W  load-use stall cycles, saturating.
- flush_cnt  out  CNT_W  redirect events, saturating.

Behaviour:
- Scoreboard registers per stage S in {ex, mem, wb}: S_valid, S_rd, S_rf_write, S_is_load. EX additionally holds ex_rs1, ex_rs2, ex_use1, ex_use2.
- A stage "writes r" when S_valid & S_rf_write & S_rd == r & r != 0. Register 0 never creates a hazard and is never forwarded.
- Condition luse: EX holds a load that writes (id_use_rs1 ? id_rs1 : none) or (id_use_rs2 ? id_rs2 : none), and id_valid = 1.
- Cycle mode is chosen by priority, highest first:
  1. FREEZE (dmem_busy = 1): pc_en = 0, ifid_en = 0, pipe_en = 0, no flush/bubble. Scoreboard holds. A concurrent ex_redirect is ignored this cycle; it stays asserted because EX is frozen.
  2. REDIRECT (ex_redirect = 1): pc_en = 1, ifid_en = 1, ifid_flush = 1, idex_bubble = 1, pipe_en = 1. Scoreboard: ex is invalidated, mem <= ex, wb <= mem. flush_cnt increments. A concurrent luse is discarded and not counted.
  3. LOADUSE (luse = 1): pc_en = 0, ifid_en = 0, idex_bubble = 1, pipe_en = 1. Scoreboard: ex is invalidated, mem <= ex, wb <= mem. stall_cnt increments.
  4. RUN: all enables 1, no flush/bubble. Scoreboard: ex <= ID fields with ex_valid = id_valid, mem <= ex, wb <= mem.
- Load-use penalty is exactly 1 cycle. In the next cycle the load is in MEM, so forwarding from EX/MEM must not select it; the consumer takes it from MEM/WB one cycle later. The stall therefore re-evaluates against the new EX contents.
- Forwarding is combinational from scoreboard registers only; no input-to-output path.
- fwd_a = 10 when mem writes ex_rs1, ex_use1 = 1 and mem_is_load = 0.
- Otherwise fwd_a = 01 when wb writes ex_rs1 and ex_use1 = 1.
- Otherwise fwd_a = 00.
- MEM has priority over WB. fwd_b is computed the same way from ex_rs2 and ex_use2.
- The register file is write-before-read; WB→ID needs no forwarding.
- Counters saturate at 2^CNT_W − 1 and never wrap.
- Reset:
  - While rst = 1: all scoreboard valids = 0, counters = 0.
  - Outputs while rst = 1: pc_en = 0, ifid_en = 0, ifid_flush = 1, idex_bubble = 1, pipe_en = 1, fwd_a = fwd_b = 00.
  - First cycle after release is RUN with an empty scoreboard.
  - Reset asserted mid-stall or mid-freeze aborts the stall or freeze immediately.

Optional Feature:
- Macro RISC_HAZARD_FWD_EN.
- Defined: forwarding operates as described above.
- Undefined:
  - fwd_a and fwd_b are tied to 00.
  - luse is replaced by a RAW condition: ex or mem writes a used ID source, for any instruction type, not only loads.
  - Stall behaviour and counting are the same as LOADUSE.
  - The RAW stall therefore lasts up to 2 cycles per dependency; WB is covered by write-before-read.

Test Plan:
- Reset held for 3 cycles, then released; drive `add r3,r1,r2` then `sub r4,r3,r5` → after release pc_en = 1 and counters = 0. When sub reaches EX, fwd_a = 10 and fwd_b = 00.
- Sequence `lw r6,0(r1)`; `add r7,r6,r6` → 1 cycle with pc_en = 0 and idex_bubble = 1, then stall_cnt = 1. When add is in EX, fwd_a = fwd_b = 01.
- ex_redirect pulses for 1 cycle while ID holds a load-use victim → ifid_flush = 1, idex_bubble = 1, pc_en = 1, flush_cnt = 1, stall_cnt unchanged.
- dmem_busy held for 4 cycles together with ex_redirect → pc_en = pipe_en = 0 for 4 cycles and flush_cnt unchanged. On the 5th cycle REDIRECT occurs and flush_cnt increments.
- Writer to r0 followed by a reader of r0 → no stall and fwd = 00. With CNT_W = 2 and 5 load-use stalls, stall_cnt saturates at 3.
- With RISC_HAZARD_FWD_EN undefined: `add r3,...` then `or r8,r3,r0` → 2 stall cycles, stall_cnt = 2, fwd always 00.
